// File: rtl/alu_operand_stage.sv
// ID/EX operand slot ahead of the ALU: registers decoded operands/control behind a
// single-entry valid/ready handshake and forwards EX/MEM and MEM/WB results into SrcA/SrcB.
module alu_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic                  Flush,
  input  logic [XLEN-1:0]       RD1,
  input  logic [XLEN-1:0]       RD2,
  input  logic [XLEN-1:0]       PCIn,
  input  logic [XLEN-1:0]       ImmExtIn,
  input  logic [REG_ADDR_W-1:0] Rs1In,
  input  logic [REG_ADDR_W-1:0] Rs2In,
  input  logic [REG_ADDR_W-1:0] RdIn,
  input  logic                  ALUSrcAIn,
  input  logic                  ALUSrcBIn,
  input  logic [3:0]            ALUControlIn,
  input  logic                  RegWriteIn,
  input  logic                  MemRegWrite,
  input  logic [REG_ADDR_W-1:0] MemRd,
  input  logic [XLEN-1:0]       MemResult,
  input  logic                  WbRegWrite,
  input  logic [REG_ADDR_W-1:0] WbRd,
  input  logic [XLEN-1:0]       WbResult,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [XLEN-1:0]       SrcA,
  output logic [XLEN-1:0]       SrcB,
  output logic [3:0]            ALUControl,
  output logic [XLEN-1:0]       StoreData,
  output logic [REG_ADDR_W-1:0] RdOut,
  output logic                  RegWriteOut
);

  logic                  valid_q,     valid_d;
  logic [XLEN-1:0]       rs1_val_q,   rs1_val_d;
  logic [XLEN-1:0]       rs2_val_q,   rs2_val_d;
  logic [XLEN-1:0]       pc_q,        pc_d;
  logic [XLEN-1:0]       imm_q,       imm_d;
  logic [REG_ADDR_W-1:0] rs1_idx_q,   rs1_idx_d;
  logic [REG_ADDR_W-1:0] rs2_idx_q,   rs2_idx_d;
  logic [REG_ADDR_W-1:0] rd_q,        rd_d;
  logic                  src_a_sel_q, src_a_sel_d;
  logic                  src_b_sel_q, src_b_sel_d;
  logic [3:0]            alu_ctrl_q,  alu_ctrl_d;
  logic                  reg_write_q, reg_write_d;

  logic            load;
  logic            stall;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  // MEM/WB value for a register if write-back is retiring it this cycle; x0 never matches.
  function automatic logic [XLEN-1:0] wb_pick(
    input logic [REG_ADDR_W-1:0] idx,
    input logic [XLEN-1:0]       dflt,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [XLEN-1:0]       wb_res
  );
    if (wb_we && (wb_rd == idx) && (idx != '0)) return wb_res;
    return dflt;
  endfunction

  // Youngest producer wins: EX/MEM first, then MEM/WB, then the held operand.
  function automatic logic [XLEN-1:0] fwd_pick(
    input logic [REG_ADDR_W-1:0] idx,
    input logic [XLEN-1:0]       held,
    input logic                  mem_we,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic [XLEN-1:0]       mem_res,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [XLEN-1:0]       wb_res
  );
    if (idx == '0) return held;
    if (mem_we && (mem_rd == idx)) return mem_res;
    return wb_pick(idx, held, wb_we, wb_rd, wb_res);
  endfunction

  assign InReady = !valid_q || OutReady;

  always_comb begin
    load  = InValid && InReady && !Flush;
    stall = valid_q && !OutReady;

    valid_d     = valid_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    rs1_idx_d   = rs1_idx_q;
    rs2_idx_d   = rs2_idx_q;
    rd_d        = rd_q;
    src_a_sel_d = src_a_sel_q;
    src_b_sel_d = src_b_sel_q;
    alu_ctrl_d  = alu_ctrl_q;
    reg_write_d = reg_write_q;

    if (Flush)         valid_d = 1'b0;
    else if (load)     valid_d = 1'b1;
    else if (OutReady) valid_d = 1'b0;

    if (load) begin
      rs1_val_d   = wb_pick(Rs1In, RD1, WbRegWrite, WbRd, WbResult);
      rs2_val_d   = wb_pick(Rs2In, RD2, WbRegWrite, WbRd, WbResult);
      pc_d        = PCIn;
      imm_d       = ImmExtIn;
      rs1_idx_d   = Rs1In;
      rs2_idx_d   = Rs2In;
      rd_d        = RdIn;
      src_a_sel_d = ALUSrcAIn;
      src_b_sel_d = ALUSrcBIn;
      alu_ctrl_d  = ALUControlIn;
      reg_write_d = RegWriteIn;
    end else if (stall) begin
      // A producer retiring while we wait would otherwise leave a stale operand behind.
      rs1_val_d = wb_pick(rs1_idx_q, rs1_val_q, WbRegWrite, WbRd, WbResult);
      rs2_val_d = wb_pick(rs2_idx_q, rs2_val_q, WbRegWrite, WbRd, WbResult);
    end
  end

  // ---- slot register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_idx_q   <= '0;
      rs2_idx_q   <= '0;
      rd_q        <= '0;
      src_a_sel_q <= 1'b0;
      src_b_sel_q <= 1'b0;
      alu_ctrl_q  <= 4'b0000;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      rs1_idx_q   <= rs1_idx_d;
      rs2_idx_q   <= rs2_idx_d;
      rd_q        <= rd_d;
      src_a_sel_q <= src_a_sel_d;
      src_b_sel_q <= src_b_sel_d;
      alu_ctrl_q  <= alu_ctrl_d;
      reg_write_q <= reg_write_d;
    end
  end

  // ---- forwarding and operand select ----
  always_comb begin
    fwd_a = fwd_pick(rs1_idx_q, rs1_val_q, MemRegWrite, MemRd, MemResult,
                     WbRegWrite, WbRd, WbResult);
    fwd_b = fwd_pick(rs2_idx_q, rs2_val_q, MemRegWrite, MemRd, MemResult,
                     WbRegWrite, WbRd, WbResult);
  end

  assign OutValid    = valid_q;
  assign SrcA        = src_a_sel_q ? pc_q  : fwd_a;
  assign SrcB        = src_b_sel_q ? imm_q : fwd_b;
  assign StoreData   = fwd_b;
  assign ALUControl  = alu_ctrl_q;
  assign RdOut       = rd_q;
  assign RegWriteOut = reg_write_q && valid_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed forwarding/stall/flush/reset cases, then a random
// stream scored against a register-file model where each operand is the newest value of its register.
module tb_alu_operand_stage;

  logic        clk, reset;
  logic        InValid, InReady, Flush;
  logic [31:0] RD1, RD2, PCIn, ImmExtIn;
  logic [4:0]  Rs1In, Rs2In, RdIn;
  logic        ALUSrcAIn, ALUSrcBIn;
  logic [3:0]  ALUControlIn;
  logic        RegWriteIn;
  logic        MemRegWrite, WbRegWrite;
  logic [4:0]  MemRd, WbRd;
  logic [31:0] MemResult, WbResult;
  logic        OutValid, OutReady;
  logic [31:0] SrcA, SrcB, StoreData;
  logic [3:0]  ALUControl;
  logic [4:0]  RdOut;
  logic        RegWriteOut;

  alu_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady), .Flush(Flush),
    .RD1(RD1), .RD2(RD2), .PCIn(PCIn), .ImmExtIn(ImmExtIn),
    .Rs1In(Rs1In), .Rs2In(Rs2In), .RdIn(RdIn),
    .ALUSrcAIn(ALUSrcAIn), .ALUSrcBIn(ALUSrcBIn), .ALUControlIn(ALUControlIn),
    .RegWriteIn(RegWriteIn),
    .MemRegWrite(MemRegWrite), .MemRd(MemRd), .MemResult(MemResult),
    .WbRegWrite(WbRegWrite), .WbRd(WbRd), .WbResult(WbResult),
    .OutValid(OutValid), .OutReady(OutReady),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .StoreData(StoreData),
    .RdOut(RdOut), .RegWriteOut(RegWriteOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, imm;
    logic        sa, sb, rw;
    logic [3:0]  ctrl;
  } ent_t;

  ent_t        sbq[$];
  logic [31:0] regs[32];
  logic [3:0]  ops[10] = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7};
  int          checks = 0, failures = 0;
  int          n_acc = 0, n_pop = 0;
  bit          took = 0, sb_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] pc, input logic [31:0] imm,
                             input logic sa, input logic sb, input logic [3:0] ctrl,
                             input logic rw);
    Rs1In = rs1; Rs2In = rs2; RdIn = rd; RD1 = d1; RD2 = d2; PCIn = pc; ImmExtIn = imm;
    ALUSrcAIn = sa; ALUSrcBIn = sb; ALUControlIn = ctrl; RegWriteIn = rw; InValid = 1'b1;
  endtask

  // Newest architectural value of a register as seen by an instruction in the slot this cycle.
  function automatic logic [31:0] newest(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (MemRegWrite && MemRd == r) return MemResult;
    if (WbRegWrite && WbRd == r) return WbResult;
    return regs[r];
  endfunction

  // One random-phase cycle: retire write-back into the model, advance the producer pipe, offer.
  task automatic rand_cycle(input bit allow_new, input bit stalls);
    ent_t e;
    @(posedge clk);
    if (WbRegWrite && WbRd != 5'd0) regs[WbRd] = WbResult;
    #1;
    WbRegWrite  = MemRegWrite; WbRd = MemRd; WbResult = MemResult;
    MemRegWrite = 1'($urandom_range(0, 1));
    MemRd       = 5'($urandom_range(0, 7));
    MemResult   = $urandom;
    if (!allow_new) InValid = 1'b0;
    else if (!InValid || took) begin
      InValid      = ($urandom_range(0, 3) != 0);
      Rs1In        = 5'($urandom_range(0, 7));
      Rs2In        = 5'($urandom_range(0, 7));
      RdIn         = 5'($urandom_range(0, 31));
      PCIn         = $urandom;
      ImmExtIn     = $urandom;
      ALUSrcAIn    = 1'($urandom_range(0, 1));
      ALUSrcBIn    = 1'($urandom_range(0, 1));
      ALUControlIn = ops[$urandom_range(0, 9)];
      RegWriteIn   = 1'($urandom_range(0, 1));
    end
    RD1 = regs[Rs1In];
    RD2 = regs[Rs2In];
    OutReady = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
    @(negedge clk);
    took = InValid && InReady;
    if (took) begin
      e.rs1 = Rs1In; e.rs2 = Rs2In; e.rd = RdIn; e.pc = PCIn; e.imm = ImmExtIn;
      e.sa = ALUSrcAIn; e.sb = ALUSrcBIn; e.ctrl = ALUControlIn; e.rw = RegWriteIn;
      sbq.push_back(e);
      n_acc++;
    end
  endtask

  // Monitor: checks the oldest outstanding instruction every cycle it is presented.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (sb_en && OutValid) begin
        if (sbq.size() == 0) begin
          chk("sb_spurious_out", 32'(OutValid), 32'h0);
        end else begin
          e = sbq[0];
          chk("sb_srca",  SrcA,      e.sa ? e.pc : newest(e.rs1));
          chk("sb_srcb",  SrcB,      e.sb ? e.imm : newest(e.rs2));
          chk("sb_store", StoreData, newest(e.rs2));
          chk("sb_ctrl",  32'(ALUControl),  32'(e.ctrl));
          chk("sb_rd",    32'(RdOut),       32'(e.rd));
          chk("sb_rw",    32'(RegWriteOut), 32'(e.rw));
          if (OutReady) begin
            void'(sbq.pop_front());
            n_pop++;
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    RD1 = '0; RD2 = '0; PCIn = '0; ImmExtIn = '0; Rs1In = '0; Rs2In = '0; RdIn = '0;
    ALUSrcAIn = 1'b0; ALUSrcBIn = 1'b0; ALUControlIn = 4'h0; RegWriteIn = 1'b0;
    MemRegWrite = 1'b0; MemRd = '0; MemResult = '0;
    WbRegWrite = 1'b0; WbRd = '0; WbResult = '0;
    #3;
    chk("rst_outvalid", 32'(OutValid), 32'h0);
    chk("rst_regwrite", 32'(RegWriteOut), 32'h0);
    chk("rst_srca", SrcA, 32'h0);
    chk("rst_srcb", SrcB, 32'h0);
    chk("rst_store", StoreData, 32'h0);
    chk("rst_ctrl", 32'(ALUControl), 32'h0);
    tick();
    reset = 1'b0;

    // Basic load, one-cycle latency
    drive_instr(5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1);
    tick();
    InValid = 1'b0;
    @(negedge clk);
    chk("basic_valid", 32'(OutValid), 32'h1);
    chk("basic_srca", SrcA, 32'd10);
    chk("basic_srcb", SrcB, 32'd20);
    chk("basic_ctrl", 32'(ALUControl), 32'h0);
    chk("basic_rd", 32'(RdOut), 32'd3);
    chk("basic_rw", 32'(RegWriteOut), 32'h1);
    tick();
    @(negedge clk);
    chk("basic_consumed", 32'(OutValid), 32'h0);

    // EX/MEM over MEM/WB priority, then x0 never forwarded
    tick();
    OutReady = 1'b0;
    drive_instr(5'd5, 5'd6, 5'd1, 32'd1, 32'd2, 32'h0, 32'h0, 1'b0, 1'b0, 4'h8, 1'b1);
    tick();
    InValid = 1'b0;
    MemRegWrite = 1'b1; MemRd = 5'd5; MemResult = 32'hAA;
    WbRegWrite  = 1'b1; WbRd  = 5'd5; WbResult  = 32'hBB;
    @(negedge clk);
    chk("fwd_mem_wins", SrcA, 32'hAA);
    tick();
    MemRegWrite = 1'b0;
    @(negedge clk);
    chk("fwd_wb", SrcA, 32'hBB);
    tick();
    WbRegWrite = 1'b0;
    @(negedge clk);
    chk("fwd_wb_captured", SrcA, 32'hBB);
    tick();
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    drive_instr(5'd0, 5'd6, 5'd1, 32'd1, 32'd2, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1);
    tick();
    InValid = 1'b0;
    MemRegWrite = 1'b1; MemRd = 5'd0; MemResult = 32'hAA;
    WbRegWrite  = 1'b1; WbRd  = 5'd0; WbResult  = 32'hBB;
    @(negedge clk);
    chk("fwd_x0", SrcA, 32'd1);
    tick();
    MemRegWrite = 1'b0; WbRegWrite = 1'b0; OutReady = 1'b1;
    tick();

    // Stall with write-back retiring rs2 mid-stall
    OutReady = 1'b0;
    drive_instr(5'd6, 5'd7, 5'd2, 32'h0, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    drive_instr(5'd9, 5'd0, 5'd4, 32'h77, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h4, 1'b1);
    @(negedge clk);
    chk("stall_c1_store", StoreData, 32'h55);
    chk("stall_c1_inready", 32'(InReady), 32'h0);
    tick();
    WbRegWrite = 1'b1; WbRd = 5'd7; WbResult = 32'h1234;
    @(negedge clk);
    chk("stall_c2_store", StoreData, 32'h1234);
    chk("stall_c2_inready", 32'(InReady), 32'h0);
    tick();
    WbRegWrite = 1'b0;
    @(negedge clk);
    chk("stall_c3_store", StoreData, 32'h1234);
    chk("stall_c3_inready", 32'(InReady), 32'h0);
    tick();
    OutReady = 1'b1;
    @(negedge clk);
    chk("stall_c4_store", StoreData, 32'h1234);
    chk("stall_c4_inready", 32'(InReady), 32'h1);
    tick();
    InValid = 1'b0;
    @(negedge clk);
    chk("stall_next_valid", 32'(OutValid), 32'h1);
    chk("stall_next_srca", SrcA, 32'h77);
    chk("stall_next_ctrl", 32'(ALUControl), 32'h4);
    tick();

    // PC / immediate operand select; StoreData still forwarded rs2
    OutReady = 1'b0;
    drive_instr(5'd2, 5'd3, 5'd8, 32'hDEAD, 32'h33, 32'h100, 32'hFFFFFFFC, 1'b1, 1'b1, 4'h0, 1'b1);
    tick();
    InValid = 1'b0;
    MemRegWrite = 1'b1; MemRd = 5'd3; MemResult = 32'h99;
    @(negedge clk);
    chk("sel_srca_pc", SrcA, 32'h100);
    chk("sel_srcb_imm", SrcB, 32'hFFFFFFFC);
    chk("sel_store_fwd", StoreData, 32'h99);
    tick();
    MemRegWrite = 1'b0; OutReady = 1'b1;
    tick();

    // Flush kills live slot and same-cycle load
    OutReady = 1'b0;
    drive_instr(5'd1, 5'd2, 5'd9, 32'h1, 32'h2, 32'h0, 32'h0, 1'b0, 1'b0, 4'h7, 1'b1);
    tick();
    InValid = 1'b0;
    @(negedge clk);
    chk("flush_pre_valid", 32'(OutValid), 32'h1);
    chk("flush_pre_rw", 32'(RegWriteOut), 32'h1);
    tick();
    OutReady = 1'b1; Flush = 1'b1;
    drive_instr(5'd3, 5'd4, 5'd10, 32'h3, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 4'h6, 1'b1);
    tick();
    Flush = 1'b0; InValid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(OutValid), 32'h0);
    chk("flush_rw", 32'(RegWriteOut), 32'h0);
    tick();
    @(negedge clk);
    chk("flush_no_load", 32'(OutValid), 32'h0);

    // Asynchronous reset in the middle of a stall
    tick();
    OutReady = 1'b0;
    drive_instr(5'd1, 5'd2, 5'd11, 32'h5, 32'h6, 32'h0, 32'h0, 1'b0, 1'b0, 4'h1, 1'b1);
    tick();
    InValid = 1'b0;
    @(negedge clk);
    chk("rstmid_pre_valid", 32'(OutValid), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_valid", 32'(OutValid), 32'h0);
    chk("rstmid_rw", 32'(RegWriteOut), 32'h0);
    chk("rstmid_srca", SrcA, 32'h0);
    #1 reset = 1'b0;
    OutReady = 1'b1;
    drive_instr(5'd4, 5'd0, 5'd12, 32'h4444, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h3, 1'b1);
    tick();
    InValid = 1'b0;
    @(negedge clk);
    chk("rstmid_accept_valid", 32'(OutValid), 32'h1);
    chk("rstmid_accept_srca", SrcA, 32'h4444);
    tick();
    tick();

    // Random stream: 100 at full throughput, then 100 with random stalls
    regs[0] = 32'h0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    took = 1'b0;
    sb_en = 1'b1;
    for (int cyc = 0; cyc < 4000 && n_acc < 200; cyc++) rand_cycle(1'b1, n_acc >= 100);
    for (int cyc = 0; cyc < 20 && sbq.size() != 0; cyc++) rand_cycle(1'b0, 1'b0);
    rand_cycle(1'b0, 1'b0);
    sb_en = 1'b0;
    chk("rand_accepted", 32'(n_acc), 32'd200);
    chk("rand_drained", 32'(sbq.size()), 32'd0);
    chk("rand_popped", 32'(n_pop), 32'(n_acc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline slot directly upstream of the ALU. Registers decoded operands and control from decode, then resolves data hazards by forwarding from the EX/MEM and MEM/WB stages.
- Drives SrcA, SrcB and ALUControl into the ALU, plus StoreData, Rd and RegWrite to the downstream stage.
- Uses a single-entry valid/ready slot with stall hold, synchronous flush and write-back capture while stalled.

Parameters:
- XLEN, 32, datapath width of operands, PC and results.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- InValid  in  1  decode offers an instruction.
- InReady  out  1  slot can accept this cycle.
- Flush  in  1  kill slot contents and any incoming instruction.
- RD1, RD2  in  XLEN  register-file read data for rs1/rs2.
- PCIn  in  XLEN  instruction PC.
- ImmExtIn  in  XLEN  sign-extended immediate.
- Rs1In, Rs2In, RdIn  in  REG_ADDR_W  source and destination indices.
- ALUSrcAIn  in  1  0 = rs1, 1 = PC.
- ALUSrcBIn  in  1  0 = rs2, 1 = immediate.
- ALUControlIn  in  4  ALU opcode: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
- RegWriteIn  in  1  instruction writes Rd.
- MemRegWrite  in  1  EX/MEM-stage write enable.
- MemRd  in  REG_ADDR_W  EX/MEM-stage destination index.
- MemResult  in  XLEN  EX/MEM-stage result.
- WbRegWrite  in  1  MEM/WB-stage write enable.
- WbRd  in  REG_ADDR_W  MEM/WB-stage destination index.
- WbResult  in  XLEN  MEM/WB-stage result.
- OutValid  out  1  slot holds a live instruction.
- OutReady  in  1  ALU/EX stage consumes this cycle.
- SrcA, SrcB  out  XLEN  ALU operands.
- ALUControl  out  4  registered opcode.
- StoreData  out  XLEN  forwarded rs2 value.
- RdOut  out  REG_ADDR_W  registered destination index.
- RegWriteOut  out  1  RegWrite_q AND OutValid.

Behaviour:
Reset (asynchronous, immediate):
- valid_q = 0; all data and index registers = 0; ALUControl = 0000.
- Outputs at reset: OutValid = 0, RegWriteOut = 0, SrcA = SrcB = StoreData = 0.

Handshake:
- InReady = !valid_q || OutReady (combinational).
- Load on clock edge when InValid && InReady; valid_q <= 1.
- Consume without load (OutValid && OutReady && !(InValid && InReady)): valid_q <= 0.
- Latency: exactly 1 cycle from accepted input to OutValid.
- Back-to-back transfers sustain one instruction per cycle.

Flush:
- Synchronous, highest priority: valid_q <= 0 and any same-cycle load is discarded.
- Flush concurrent with reset: reset wins.

Load-time bypass:
- If WbRegWrite && WbRd == Rs1In && Rs1In != 0, rs1_q captures WbResult instead of RD1. Same rule for rs2.

Stall capture:
- While valid_q && !OutReady, if WbRegWrite && WbRd == Rs1_q && Rs1_q != 0, then rs1_q <= WbResult. Same for rs2.
- This prevents a stale operand when the producer retires during the stall.

Forwarding (combinational from registered indices, applies every cycle):
- fwdA = MemResult if MemRegWrite && MemRd == Rs1_q && Rs1_q != 0.
- Otherwise fwdA = WbResult if WbRegWrite && WbRd == Rs1_q && Rs1_q != 0.
- Otherwise fwdA = rs1_q.
- fwdB uses the same rule with Rs2_q and rs2_q.
- EX/MEM has priority over MEM/WB. x0 is never forwarded.

Output selection:
- SrcA = ALUSrcA_q ? PC_q : fwdA.
- SrcB = ALUSrcB_q ? Imm_q : fwdB.
- StoreData = fwdB regardless of ALUSrcB_q.
- When OutValid = 0, data outputs hold their last values; consumers must gate on OutValid.

Reset mid-stall:
- Slot empties immediately; a new instruction is accepted on the first edge after reset deassertion.

Test Plan:
- Reset deasserts, then InValid with RD1=10, RD2=20, ALUControl 0000, ALUSrc=00 -> next cycle OutValid=1, SrcA=10, SrcB=20, ALUControl=0000.
- Slot holds Rs1=5 with rs1_q=1; MemRegWrite=1, MemRd=5, MemResult=0xAA; WbRegWrite=1, WbRd=5, WbResult=0xBB -> SrcA=0xAA (EX/MEM wins). Repeat with Rs1=0 and MemRd=0 -> SrcA=1.
- OutReady=0 for 3 cycles with a live slot (Rs2=7); WB writes 7 with 0x1234 in cycle 2 and Mem* idle thereafter -> StoreData=0x1234 in cycles 3 and 4; InReady=0 throughout; the new input is accepted on the cycle OutReady=1.
- ALUSrcA=1, PC=0x100, ALUSrcB=1, Imm=0xFFFFFFFC, ALUControl 0000 -> SrcA=0x100, SrcB=0xFFFFFFFC, StoreData = forwarded rs2.
- Flush asserted with InValid=1 and a live slot -> next cycle OutValid=0 and RegWriteOut=0; the incoming instruction is not loaded.
- Stream 100 random instructions against a reference model at OutReady=1, then with random stalls -> every accepted instruction emerges exactly once, in order, with correct forwarded operands.
